// File: rtl/ddr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr_pkg : shared encodings and helpers for the DDR ring-buffer arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package ddr_pkg;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_wr_req  = 3'd1;
  localparam logic [2:0] c_st_wr_busy = 3'd2;
  localparam logic [2:0] c_st_rd_req  = 3'd3;
  localparam logic [2:0] c_st_rd_busy = 3'd4;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  function automatic int unsigned min3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_ring_ptr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr_ring_ptr : ring write/read pointers and committed fill level
// Rev 1.0
// ----------------------------------------------------------------------------
module ddr_ring_ptr
  import ddr_pkg::*;
#(
  parameter int unsigned RING_BEATS = 1048576,
  parameter int unsigned PW         = $clog2(RING_BEATS)
) (
  input  logic          ddr_clk_i,
  input  logic          ddr_rst_n_i,
  input  logic          commit_i,
  input  grant_t        commit_sel_i,
  input  logic [7:0]    commit_len_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [PW:0]   level_o,
  output logic [PW:0]   free_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [PW:0] c_ring_beats = (PW+1)'(RING_BEATS);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;

  // Pointers wrap by natural PW-bit overflow; bursts never straddle the wrap.
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (commit_i) begin
      if (commit_sel_i == GNT_WR) begin
        r_wr_ptr <= r_wr_ptr + PW'(commit_len_i);
        r_level  <= r_level + (PW+1)'(commit_len_i);
      end else begin
        r_rd_ptr <= r_rd_ptr + PW'(commit_len_i);
        r_level  <= r_level - (PW+1)'(commit_len_i);
      end
    end
  end

  assign wr_ptr_o = r_wr_ptr;
  assign rd_ptr_o = r_rd_ptr;
  assign level_o  = r_level;
  assign free_o   = c_ring_beats - r_level;
  assign full_o   = (r_level == c_ring_beats);
  assign empty_o  = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/ddr_ring_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr_ring_arbiter : DDR used as a ring buffer between ingress and egress FIFOs
// Rev 1.0
// ----------------------------------------------------------------------------
module ddr_ring_arbiter
  import ddr_pkg::*;
#(
  parameter real         TCQ           = 0.1,
  parameter int unsigned MEM_DATA_BITS = 256,
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned ADDR_STEP     = 8,
  parameter int unsigned RING_BASE     = 0,
  parameter int unsigned RING_BEATS    = 1048576,
  parameter int unsigned PW            = $clog2(RING_BEATS)
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     local_init_done_i,
  input  logic                     flush_i,
  input  logic [MEM_DATA_BITS-1:0] wfifo_rd_data_i,
  input  logic [15:0]              wfifo_count_i,
  output logic                     wfifo_rd_en_o,
  output logic                     rfifo_wr_en_o,
  output logic [MEM_DATA_BITS-1:0] rfifo_wr_data_o,
  input  logic [15:0]              rfifo_space_i,
  output logic                     wr_ddr_req_o,
  output logic [7:0]               wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
  input  logic                     wr_ddr_data_req_i,
  output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
  input  logic                     wr_ddr_finish_i,
  output logic                     rd_ddr_req_o,
  output logic [7:0]               rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
  input  logic                     rd_ddr_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
  input  logic                     rd_ddr_finish_i,
  output logic [PW:0]              ring_level_o,
  output logic                     ring_full_o,
  output logic                     ring_empty_o,
  output logic                     burst_abort_o
);

  if (BURST_LEN < 1 || BURST_LEN > 255 || (RING_BEATS % BURST_LEN) != 0 ||
      (RING_BEATS & (RING_BEATS - 1)) != 0 || TCQ < 0.0) begin : g_param_check
    $error("ddr_ring_arbiter: invalid parameterisation");
  end

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  grant_t                r_last_grant;
  logic [7:0]            r_wr_len;
  logic [7:0]            r_rd_len;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_abort;

  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic [PW:0]           w_level;
  logic [PW:0]           w_free;
  int unsigned           w_wlen;
  int unsigned           w_rlen;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_in_wr;
  logic                  w_in_rd;
  logic                  w_wr_done;
  logic                  w_rd_done;
  logic                  w_abort;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Burst length is clipped so a burst never runs past the end of the ring.
  always_comb begin
    w_wlen = min3(BURST_LEN, RING_BEATS - 32'(w_wr_ptr), 32'(wfifo_count_i));
    w_rlen = min3(BURST_LEN, RING_BEATS - 32'(w_rd_ptr), 32'(w_level));
    w_wr_elig = local_init_done_i &&
                (32'(wfifo_count_i) >= BURST_LEN || (flush_i && wfifo_count_i != '0)) &&
                32'(w_free) >= w_wlen && w_wlen != 0;
    w_rd_elig = local_init_done_i &&
                (32'(w_level) >= BURST_LEN || (flush_i && w_level != '0)) &&
                32'(rfifo_space_i) >= w_rlen;
    w_grant_wr = w_wr_elig && (!w_rd_elig || r_last_grant == GNT_RD);
    w_grant_rd = w_rd_elig && !w_grant_wr;
  end

  assign w_wr_addr = ADDR_WIDTH'(RING_BASE) + ADDR_WIDTH'(w_wr_ptr) * ADDR_WIDTH'(ADDR_STEP);
  assign w_rd_addr = ADDR_WIDTH'(RING_BASE) + ADDR_WIDTH'(w_rd_ptr) * ADDR_WIDTH'(ADDR_STEP);

  assign w_in_wr   = (r_state == c_st_wr_req) || (r_state == c_st_wr_busy);
  assign w_in_rd   = (r_state == c_st_rd_req) || (r_state == c_st_rd_busy);
  assign w_abort   = (r_state != c_st_idle) && !local_init_done_i;
  assign w_wr_done = w_in_wr && wr_ddr_finish_i && local_init_done_i;
  assign w_rd_done = w_in_rd && rd_ddr_finish_i && local_init_done_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_grant_wr)      w_state_nxt = c_st_wr_req;
        else if (w_grant_rd) w_state_nxt = c_st_rd_req;
      end
      c_st_wr_req:  w_state_nxt = c_st_wr_busy;
      c_st_rd_req:  w_state_nxt = c_st_rd_busy;
      c_st_wr_busy,
      c_st_rd_busy: w_state_nxt = r_state;
      default:      w_state_nxt = c_st_idle;
    endcase
    if (w_abort || w_wr_done || w_rd_done) w_state_nxt = c_st_idle;
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      r_state      <= c_st_idle;
      r_last_grant <= GNT_RD;
      r_wr_len     <= '0;
      r_rd_len     <= '0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_abort      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= w_abort;
      if (r_state == c_st_idle && w_grant_wr) begin
        r_wr_len     <= 8'(w_wlen);
        r_wr_addr    <= w_wr_addr;
        r_last_grant <= GNT_WR;
      end
      if (r_state == c_st_idle && w_grant_rd) begin
        r_rd_len     <= 8'(w_rlen);
        r_rd_addr    <= w_rd_addr;
        r_last_grant <= GNT_RD;
      end
    end
  end

  ddr_ring_ptr #(
    .RING_BEATS (RING_BEATS),
    .PW         (PW)
  ) u_ring_ptr (
    .ddr_clk_i    (ddr_clk_i),
    .ddr_rst_n_i  (ddr_rst_n_i),
    .commit_i     (w_wr_done || w_rd_done),
    .commit_sel_i (w_rd_done ? GNT_RD : GNT_WR),
    .commit_len_i (w_rd_done ? r_rd_len : r_wr_len),
    .wr_ptr_o     (w_wr_ptr),
    .rd_ptr_o     (w_rd_ptr),
    .level_o      (w_level),
    .free_o       (w_free),
    .full_o       (ring_full_o),
    .empty_o      (ring_empty_o)
  );

  assign wr_ddr_req_o    = (r_state == c_st_wr_req);
  assign wr_ddr_len_o    = r_wr_len;
  assign wr_ddr_addr_o   = r_wr_addr;
  assign rd_ddr_req_o    = (r_state == c_st_rd_req);
  assign rd_ddr_len_o    = r_rd_len;
  assign rd_ddr_addr_o   = r_rd_addr;
  assign wfifo_rd_en_o   = (r_state == c_st_wr_busy) && wr_ddr_data_req_i;
  assign wr_ddr_data_o   = w_in_wr ? wfifo_rd_data_i : '0;
  assign rfifo_wr_en_o   = (r_state == c_st_rd_busy) && rd_ddr_data_valid_i;
  assign rfifo_wr_data_o = (r_state == c_st_rd_busy) ? rd_ddr_data_i : '0;
  assign ring_level_o    = w_level;
  assign burst_abort_o   = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_ddr_ring_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ddr_ring_arbiter : directed bench for the DDR ring arbiter (256-beat ring)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ddr_ring_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 30;
  localparam int unsigned RB = 256;

  logic          ddr_clk_i = 1'b0;
  logic          ddr_rst_n_i = 1'b0;
  logic          local_init_done_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [DW-1:0] wfifo_rd_data_i = '0;
  logic [15:0]   wfifo_count_i = '0;
  logic          wfifo_rd_en_o;
  logic          rfifo_wr_en_o;
  logic [DW-1:0] rfifo_wr_data_o;
  logic [15:0]   rfifo_space_i = '0;
  logic          wr_ddr_req_o;
  logic [7:0]    wr_ddr_len_o;
  logic [AW-1:0] wr_ddr_addr_o;
  logic          wr_ddr_data_req_i = 1'b0;
  logic [DW-1:0] wr_ddr_data_o;
  logic          wr_ddr_finish_i = 1'b0;
  logic          rd_ddr_req_o;
  logic [7:0]    rd_ddr_len_o;
  logic [AW-1:0] rd_ddr_addr_o;
  logic          rd_ddr_data_valid_i = 1'b0;
  logic [DW-1:0] rd_ddr_data_i = '0;
  logic          rd_ddr_finish_i = 1'b0;
  logic [8:0]    ring_level_o;
  logic          ring_full_o;
  logic          ring_empty_o;
  logic          burst_abort_o;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned r_seq = 0;
  logic [DW-1:0] r_mem [RB];

  always #5 ddr_clk_i = ~ddr_clk_i;

  ddr_ring_arbiter #(
    .MEM_DATA_BITS (DW),
    .ADDR_WIDTH    (AW),
    .BURST_LEN     (64),
    .ADDR_STEP     (8),
    .RING_BASE     (0),
    .RING_BEATS    (RB)
  ) dut (
    .ddr_clk_i           (ddr_clk_i),
    .ddr_rst_n_i         (ddr_rst_n_i),
    .local_init_done_i   (local_init_done_i),
    .flush_i             (flush_i),
    .wfifo_rd_data_i     (wfifo_rd_data_i),
    .wfifo_count_i       (wfifo_count_i),
    .wfifo_rd_en_o       (wfifo_rd_en_o),
    .rfifo_wr_en_o       (rfifo_wr_en_o),
    .rfifo_wr_data_o     (rfifo_wr_data_o),
    .rfifo_space_i       (rfifo_space_i),
    .wr_ddr_req_o        (wr_ddr_req_o),
    .wr_ddr_len_o        (wr_ddr_len_o),
    .wr_ddr_addr_o       (wr_ddr_addr_o),
    .wr_ddr_data_req_i   (wr_ddr_data_req_i),
    .wr_ddr_data_o       (wr_ddr_data_o),
    .wr_ddr_finish_i     (wr_ddr_finish_i),
    .rd_ddr_req_o        (rd_ddr_req_o),
    .rd_ddr_len_o        (rd_ddr_len_o),
    .rd_ddr_addr_o       (rd_ddr_addr_o),
    .rd_ddr_data_valid_i (rd_ddr_data_valid_i),
    .rd_ddr_data_i       (rd_ddr_data_i),
    .rd_ddr_finish_i     (rd_ddr_finish_i),
    .ring_level_o        (ring_level_o),
    .ring_full_o         (ring_full_o),
    .ring_empty_o        (ring_empty_o),
    .burst_abort_o       (burst_abort_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic is_wr);
    int t = 0;
    while ((is_wr ? wr_ddr_req_o : rd_ddr_req_o) !== 1'b1 && t < 200) begin
      @(negedge ddr_clk_i);
      t++;
    end
  endtask

  // ptr is the expected ring beat index; address is ptr * 8 with base 0.
  task automatic wr_burst(input string tag, input int ptr, input int len,
                          input int cnt_after, input int spc_after);
    int pops = 0;
    int bad = 0;
    wait_req(1'b1);
    check_val({tag, "_req"}, 64'(wr_ddr_req_o), 1);
    check_val({tag, "_len"}, 64'(wr_ddr_len_o), 64'(len));
    check_val({tag, "_addr"}, 64'(wr_ddr_addr_o), 64'(ptr * 8));
    @(negedge ddr_clk_i);
    check_val({tag, "_req_1cyc"}, 64'(wr_ddr_req_o), 0);
    for (int i = 0; i < len; i++) begin
      wfifo_rd_data_i   = 32'hC0DE_0000 ^ r_seq;
      wr_ddr_data_req_i = 1'b1;
      r_mem[(ptr + i) % RB] = wfifo_rd_data_i;
      #1;
      if (wfifo_rd_en_o === 1'b1) pops++;
      if (wr_ddr_data_o !== wfifo_rd_data_i) bad++;
      @(negedge ddr_clk_i);
      r_seq++;
    end
    wr_ddr_data_req_i = 1'b0;
    wr_ddr_finish_i   = 1'b1;
    @(negedge ddr_clk_i);
    wr_ddr_finish_i = 1'b0;
    wfifo_count_i   = 16'(cnt_after);
    rfifo_space_i   = 16'(spc_after);
    check_val({tag, "_pops"}, 64'(pops), 64'(len));
    check_val({tag, "_wdata_bad"}, 64'(bad), 0);
  endtask

  task automatic rd_burst(input string tag, input int ptr, input int len,
                          input int cnt_after, input int spc_after);
    int pushes = 0;
    int bad = 0;
    wait_req(1'b0);
    check_val({tag, "_req"}, 64'(rd_ddr_req_o), 1);
    check_val({tag, "_len"}, 64'(rd_ddr_len_o), 64'(len));
    check_val({tag, "_addr"}, 64'(rd_ddr_addr_o), 64'(ptr * 8));
    @(negedge ddr_clk_i);
    check_val({tag, "_req_1cyc"}, 64'(rd_ddr_req_o), 0);
    for (int i = 0; i < len; i++) begin
      rd_ddr_data_valid_i = 1'b1;
      rd_ddr_data_i       = r_mem[(ptr + i) % RB];
      #1;
      if (rfifo_wr_en_o === 1'b1) pushes++;
      if (rfifo_wr_data_o !== r_mem[(ptr + i) % RB]) bad++;
      @(negedge ddr_clk_i);
    end
    rd_ddr_data_valid_i = 1'b0;
    rd_ddr_finish_i     = 1'b1;
    @(negedge ddr_clk_i);
    rd_ddr_finish_i = 1'b0;
    wfifo_count_i   = 16'(cnt_after);
    rfifo_space_i   = 16'(spc_after);
    check_val({tag, "_pushes"}, 64'(pushes), 64'(len));
    check_val({tag, "_rdata_bad"}, 64'(bad), 0);
  endtask

  task automatic no_req_window(input string tag, input int cycles);
    int wr_seen = 0;
    int rd_seen = 0;
    repeat (cycles) begin
      @(negedge ddr_clk_i);
      if (wr_ddr_req_o === 1'b1) wr_seen++;
      if (rd_ddr_req_o === 1'b1) rd_seen++;
    end
    check_val({tag, "_wr_reqs"}, 64'(wr_seen), 0);
    check_val({tag, "_rd_reqs"}, 64'(rd_seen), 0);
  endtask

  initial begin
    wfifo_rd_data_i = 32'h1234_5678;
    repeat (3) @(negedge ddr_clk_i);
    check_val("rst_wr_req", 64'(wr_ddr_req_o), 0);
    check_val("rst_rd_req", 64'(rd_ddr_req_o), 0);
    check_val("rst_wr_len", 64'(wr_ddr_len_o), 0);
    check_val("rst_wr_addr", 64'(wr_ddr_addr_o), 0);
    check_val("rst_level", 64'(ring_level_o), 0);
    check_val("rst_empty", 64'(ring_empty_o), 1);
    check_val("rst_full", 64'(ring_full_o), 0);
    check_val("rst_abort", 64'(burst_abort_o), 0);

    ddr_rst_n_i       = 1'b1;
    local_init_done_i = 1'b1;
    @(negedge ddr_clk_i);

    // Full bursts, then a round-robin sequence with both sides eligible.
    wfifo_count_i = 16'd64;
    wr_burst("w_full", 0, 64, 64, 0);
    check_val("w_full_level", 64'(ring_level_o), 64);
    check_val("w_full_empty", 64'(ring_empty_o), 0);
    wr_burst("w_second", 64, 64, 64, 64);
    check_val("w_second_level", 64'(ring_level_o), 128);
    rd_burst("rr_r0", 0, 64, 64, 64);
    check_val("rr_r0_level", 64'(ring_level_o), 64);
    wr_burst("rr_w1", 128, 64, 64, 64);
    rd_burst("rr_r1", 64, 64, 0, 0);
    check_val("rr_level", 64'(ring_level_o), 64);

    // Short flushed write, then a burst clipped at the wrap point.
    flush_i       = 1'b1;
    wfifo_count_i = 16'd32;
    wr_burst("w_flush32", 192, 32, 0, 0);
    flush_i       = 1'b0;
    wfifo_count_i = 16'd64;
    wr_burst("wrap_a", 224, 32, 32, 0);
    flush_i = 1'b1;
    wr_burst("wrap_b", 0, 32, 0, 0);
    flush_i = 1'b0;
    check_val("wrap_level", 64'(ring_level_o), 160);

    // Egress backpressure.
    rfifo_space_i = 16'd63;
    no_req_window("bp", 12);
    rfifo_space_i = 16'd64;
    rd_burst("bp_r", 128, 64, 0, 0);
    check_val("bp_level", 64'(ring_level_o), 96);

    // Calibration loss mid write burst.
    wfifo_count_i = 16'd64;
    wait_req(1'b1);
    check_val("cal_req", 64'(wr_ddr_req_o), 1);
    check_val("cal_addr", 64'(wr_ddr_addr_o), 256);
    @(negedge ddr_clk_i);
    repeat (3) begin
      wr_ddr_data_req_i = 1'b1;
      @(negedge ddr_clk_i);
    end
    wr_ddr_data_req_i = 1'b0;
    local_init_done_i = 1'b0;
    @(negedge ddr_clk_i);
    wr_ddr_data_req_i = 1'b1;
    #1;
    check_val("cal_abort", 64'(burst_abort_o), 1);
    check_val("cal_idle_no_pop", 64'(wfifo_rd_en_o), 0);
    check_val("cal_level", 64'(ring_level_o), 96);
    wr_ddr_data_req_i = 1'b0;
    @(negedge ddr_clk_i);
    check_val("cal_abort_once", 64'(burst_abort_o), 0);
    local_init_done_i = 1'b1;
    wr_burst("cal_retry", 32, 64, 64, 0);
    wr_burst("fill_a", 96, 64, 0, 0);

    // Fill the ring completely, then confirm no write is issued.
    flush_i       = 1'b1;
    wfifo_count_i = 16'd32;
    wr_burst("fill_b", 160, 32, 0, 0);
    flush_i = 1'b0;
    check_val("full_level", 64'(ring_level_o), 256);
    check_val("full_flag", 64'(ring_full_o), 1);
    wfifo_count_i = 16'd64;
    no_req_window("full", 12);
    wfifo_count_i = 16'd0;

    rfifo_space_i = 16'd64;
    rd_burst("drain0", 192, 64, 0, 64);
    rd_burst("drain1", 0, 64, 0, 64);
    rd_burst("drain2", 64, 64, 0, 64);
    rd_burst("drain3", 128, 64, 0, 0);
    check_val("drain_level", 64'(ring_level_o), 0);
    check_val("drain_empty", 64'(ring_empty_o), 1);

    // Flushed partial write and read back.
    flush_i       = 1'b1;
    wfifo_count_i = 16'd5;
    wr_burst("fl_w", 192, 5, 0, 64);
    rd_burst("fl_r", 192, 5, 0, 0);
    flush_i = 1'b0;
    check_val("fl_level", 64'(ring_level_o), 0);
    check_val("fl_empty", 64'(ring_empty_o), 1);

    // Asynchronous reset in the middle of a write burst.
    wfifo_count_i = 16'd64;
    wr_burst("rs_w", 197, 59, 64, 0);
    check_val("rs_level_pre", 64'(ring_level_o), 59);
    wait_req(1'b1);
    check_val("rs_len", 64'(wr_ddr_len_o), 64);
    check_val("rs_addr", 64'(wr_ddr_addr_o), 0);
    @(negedge ddr_clk_i);
    wr_ddr_data_req_i = 1'b1;
    #1;
    check_val("rs_pop_busy", 64'(wfifo_rd_en_o), 1);
    #1;
    ddr_rst_n_i = 1'b0;
    #1;
    check_val("rs_async_pop", 64'(wfifo_rd_en_o), 0);
    check_val("rs_async_req", 64'(wr_ddr_req_o), 0);
    check_val("rs_async_len", 64'(wr_ddr_len_o), 0);
    check_val("rs_async_addr", 64'(wr_ddr_addr_o), 0);
    check_val("rs_async_level", 64'(ring_level_o), 0);
    check_val("rs_async_empty", 64'(ring_empty_o), 1);
    check_val("rs_async_abort", 64'(burst_abort_o), 0);
    wr_ddr_data_req_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
